// File: rtl/pipe_stage_latch_if.sv
// Handshake bundle between two pipeline stages: upstream (in_*) and downstream (out_*) sides.
// master = the surrounding pipeline/bench, slave = the stage register itself.
interface pipe_stage_latch_if #(
    parameter int INSTR_W = 16,
    parameter int PC_W    = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;
    logic [PC_W-1:0]    in_pc;
    logic               in_mem_stall;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_pc;
    logic               out_real;

    modport master (
        output in_valid, in_instr, in_pc, in_mem_stall, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_real
    );

    modport slave (
        input  in_valid, in_instr, in_pc, in_mem_stall, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_real
    );
endinterface

// File: rtl/pipe_stage_latch.sv
// IF/ID pipeline register with a 2-entry skid buffer, flush with optional NOP bubble,
// and a saturating tally of real instructions squashed by flush.
module pipe_stage_latch #(
    parameter int                 INSTR_W      = 16,
    parameter int                 PC_W         = 16,
    parameter logic [INSTR_W-1:0] NOP_INSTR    = INSTR_W'(16'h0800),
    parameter bit                 FLUSH_BUBBLE = 1'b1,
    parameter int                 CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    pipe_stage_latch_if.slave bus,
    input  logic             flush,
    output logic [CNT_W-1:0] squash_cnt
);
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
        logic               is_real;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_t;

    occ_t   state, state_n;
    entry_t h, h_n, s, s_n;
    entry_t nop_e, in_e;
    logic   acc, pop;
    logic   h_sq, s_sq, a_sq;
    logic [1:0]       inc;
    logic [CNT_W+1:0] sum;
    logic [CNT_W-1:0] cnt_n;

    assign nop_e = {NOP_INSTR, {PC_W{1'b0}}, 1'b0};
    assign in_e  = {bus.in_instr, bus.in_pc, ~bus.in_mem_stall & (bus.in_pc != '0)};

    // in_ready decodes the occupancy register only, so out_ready never reaches it.
    assign bus.in_ready  = (state != TWO);
    assign bus.out_valid = (state != EMPTY);
    assign bus.out_instr = h.instr;
    assign bus.out_pc    = h.pc;
    assign bus.out_real  = h.is_real;

    assign acc = bus.in_valid & bus.in_ready;
    assign pop = bus.out_valid & bus.out_ready;

    // A head that leaves this cycle through pop is consumed, not squashed.
    assign h_sq = (state != EMPTY) & h.is_real & ~pop;
    assign s_sq = (state == TWO) & s.is_real;
    assign a_sq = acc & in_e.is_real;
    assign inc  = flush ? (2'(h_sq) + 2'(s_sq) + 2'(a_sq)) : 2'd0;

    assign sum   = {2'b00, squash_cnt} + (CNT_W+2)'(inc);
    assign cnt_n = (|sum[CNT_W+1:CNT_W]) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];

    always_comb begin
        state_n = state;
        h_n     = h;
        s_n     = s;
        if (flush) begin
            state_n = FLUSH_BUBBLE ? ONE : EMPTY;
            h_n     = nop_e;
            s_n     = nop_e;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (acc) begin
                        state_n = ONE;
                        h_n     = in_e;
                    end
                end
                ONE: begin
                    if (acc && !pop) begin
                        state_n = TWO;
                        s_n     = in_e;
                    end else if (acc && pop) begin
                        h_n     = in_e;
                    end else if (pop) begin
                        state_n = EMPTY;
                        h_n     = nop_e;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_n = ONE;
                        h_n     = s;
                        s_n     = nop_e;
                    end
                end
                default: begin
                    state_n = EMPTY;
                    h_n     = nop_e;
                    s_n     = nop_e;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= EMPTY;
            h          <= nop_e;
            s          <= nop_e;
            squash_cnt <= '0;
        end else begin
            state      <= state_n;
            h          <= h_n;
            s          <= s_n;
            squash_cnt <= cnt_n;
        end
    end
endmodule

// File: doc/pipe_stage_latch.md
Name: pipe_stage_latch

Overview:
- Parametrised successor to the fixed 16-bit IF/ID pipeline register.
- Carries an instruction word plus PC between two pipeline stages using a valid/ready handshake.
- A 2-entry skid buffer absorbs back-pressure with no bubble.
- Branch/jump flush squashes held entries and optionally injects a NOP bubble; a saturating counter tallies squashed instructions for debug.

Parameters:
INSTR_W, 16, instruction width in bits
PC_W, 16, PC width in bits
NOP_INSTR, 16'h0800, encoding injected as bubble and shown while empty (width INSTR_W)
FLUSH_BUBBLE, 1, 1 = flush leaves one NOP bubble entry; 0 = flush leaves stage empty
CNT_W, 8, width of squash counter

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
in_valid  input  1  upstream presents an entry
in_ready  output  1  stage can accept this cycle
in_instr  input  INSTR_W  instruction from fetch
in_pc  input  PC_W  PC of in_instr
in_mem_stall  input  1  fetch data is a stall artefact; entry is not a real instruction
flush  input  1  branch/jump taken; squash contents
out_valid  output  1  head entry present
out_ready  input  1  downstream consumes head this cycle
out_instr  output  INSTR_W  head instruction (NOP_INSTR when empty)
out_pc  output  PC_W  head PC (0 when empty)
out_real  output  1  head is a genuine instruction (gates halt/dump in control)
squash_cnt  output  CNT_W  saturating count of real entries discarded by flush

Behaviour:
- Storage: head register H (drives outputs) and skid register S, each with {instr, pc, real, v}.
- Occupancy states: EMPTY (H.v=0, S.v=0), ONE (H.v=1, S.v=0), TWO (H.v=1, S.v=1).
- Outputs: in_ready = ~S.v (registered, no comb path from out_ready). out_valid = H.v. out_instr/out_pc/out_real come straight from H. H.instr is forced to NOP_INSTR, pc to 0 and real to 0 whenever H.v=0.
- Events: acc = in_valid & in_ready; pop = out_valid & out_ready.
- real captured on acc = ~in_mem_stall & (in_pc != 0).
- Transitions when flush=0:
  - EMPTY: acc -> ONE, H<=in.
  - ONE: acc & ~pop -> TWO, S<=in. acc & pop -> ONE, H<=in. ~acc & pop -> EMPTY. Neither -> hold.
  - TWO: pop -> ONE, H<=S, S.v<=0. ~pop -> hold (acc impossible).
- Latency: an entry accepted into an empty stage appears on outputs the next cycle. Sustained throughput is 1 entry/cycle with out_ready=1.
- Flush (highest priority, synchronous):
  - Discards H, S and any same-cycle input; in_ready still reads its pre-flush value but the accepted entry is dropped.
  - FLUSH_BUBBLE=1: next state ONE, H={NOP_INSTR, pc 0, real 0, v 1}.
  - FLUSH_BUBBLE=0: next state EMPTY.
  - A same-cycle pop still counts as consumed and is not counted as squashed.
- squash_cnt:
  - On flush, adds the number of real=1 entries discarded: H if not popped, S, and the accepted input if its real=1 (0..3).
  - Saturates at all-ones and never wraps.
  - Cleared only by reset.
- Reset (rst=0, asynchronous):
  - State EMPTY; out_valid=0, out_instr=NOP_INSTR, out_pc=0, out_real=0, squash_cnt=0, in_ready=1.
  - Reset asserted mid-transfer drops all entries immediately.
  - Deassertion is sampled synchronously; the first accept is possible on the first edge after release.
- Widths: no arithmetic on instr/pc. Counter add is a CNT_W-bit saturating add of a 2-bit increment.

Test Plan:
1. Reset then stream: rst low 3 cycles, then in_valid=1, out_ready=1, pc 0x0002,0x0004,0x0006 -> out_pc follows one cycle later each cycle, in_ready stays 1, out_real=1.
2. Back-pressure: fill with pc 0x0010, 0x0012, out_ready=0 -> state TWO, in_ready=0, out_pc=0x0010. Then out_ready=1 -> 0x0010 then 0x0012 delivered with no loss or duplication.
3. Flush in TWO, FLUSH_BUBBLE=1, both entries real, no pop -> next cycle out_valid=1, out_instr=0x0800, out_pc=0, out_real=0, squash_cnt increments by 2.
4. Flush with simultaneous pop and accept (state ONE, out_ready=1, in_valid=1 real) -> head consumed, squash_cnt increments by 1, bubble presented. Rerun with FLUSH_BUBBLE=0 -> out_valid=0.
5. Non-real entries: accept in_pc=0x0000, then in_mem_stall=1 with pc 0x0020 -> out_real=0 for both. Flush them -> squash_cnt unchanged.
6. Saturation and async reset: CNT_W=2, issue 3 flushes each squashing 2 real entries -> squash_cnt=3 and holds. Assert rst mid-cycle -> outputs return to reset values before the next clock edge.
